// File: rtl/m_icache_pkg.sv
// m_icache_pkg: shared state encoding, NOP word and geometry helpers for the instruction cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE/REQ/FILL), NOP, default geometry, width helpers off_w/idx_w/tag_w.
package m_icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // addi x0,x0,0 -- presented to IF whenever there is no hit
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // 30 = 32 address bits minus the two ignored byte-offset bits
    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/m_icache_data.sv
// m_icache_data: LINES*WORDS x 32 instruction data array.
// Latency: read is combinational from raddr_i; write lands on the rising edge of clk_i.
// Backpressure: none, one write per cycle accepted unconditionally.
// Ports: clk_i, we_i/waddr_i/wdata_i (sync write), raddr_i -> rdata_o (async read).
module m_icache_data #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // Contents are never reset; the valid bits in the parent guard every read.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_icache.sv
// m_icache: direct-mapped instruction cache in front of IF, refilling whole lines from backing memory.
// Latency: hit returns w_ir in the same cycle; miss costs 1 miss + 1+ REQ + WORDS FILL cycles, hit on the next.
// Backpressure: w_stall holds fetch during a miss/refill; w_mreq is held with a stable w_maddr until w_mack.
// Ports: fetch side w_req/w_pc/w_inv -> w_ir/w_hit/w_stall; refill side w_mreq/w_maddr <- w_mack/w_mvalid/w_mdata.
module m_icache
    import m_icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req,
    input  logic [31:0] w_pc,
    input  logic        w_inv,
    output logic [31:0] w_ir,
    output logic        w_hit,
    output logic        w_stall,
    output logic        w_mreq,
    output logic [31:0] w_maddr,
    input  logic        w_mack,
    input  logic        w_mvalid,
    input  logic [31:0] w_mdata
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WORDS);
    localparam int AW    = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    state_t              state_q;
    logic [OFF_W-1:0]    cnt_q;
    logic [LINES-1:0]    valid_q;
    logic                inv_pend_q;
    logic                mreq_q;
    logic [31:0]         maddr_q;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [OFF_W-1:0]    pc_off;
    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                lookup_hit;
    logic                lookup_miss;
    logic                beat_we;
    logic                fill_done;
    logic [31:0]         rd_word;
    logic                unused_pc_lsbs;

    assign pc_off = w_pc[OFF_W+1:2];
    assign pc_idx = w_pc[OFF_W+2 +: IDX_W];
    assign pc_tag = w_pc[31 -: TAG_W];

    // The line being refilled is identified entirely by the latched refill address,
    // so a redirected w_pc during REQ/FILL cannot disturb it.
    assign fill_idx = maddr_q[OFF_W+2 +: IDX_W];
    assign fill_tag = maddr_q[31 -: TAG_W];

    assign lookup_hit  = w_req && (state_q == ST_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign lookup_miss = w_req && (state_q == ST_IDLE) && !lookup_hit;
    assign beat_we     = (state_q == ST_FILL) && w_mvalid;
    assign fill_done   = beat_we && (cnt_q == LAST_BEAT);

    assign unused_pc_lsbs = ^w_pc[1:0];

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
            mreq_q     <= 1'b0;
            maddr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Same-cycle lookup already used the old valid bits; a miss may start on this edge too.
                    if (w_inv) begin
                        valid_q <= '0;
                    end
                    if (lookup_miss) begin
                        state_q <= ST_REQ;
                        mreq_q  <= 1'b1;
                        maddr_q <= {w_pc[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                    end
                end
                ST_REQ: begin
                    if (w_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (w_mack) begin
                        state_q <= ST_FILL;
                        mreq_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_inv && !fill_done) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (beat_we) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                    end
                    if (fill_done) begin
                        state_q    <= ST_IDLE;
                        inv_pend_q <= 1'b0;
                        // A fence.i seen during the refill wins: the new line is left invalid as well.
                        if (inv_pend_q || w_inv) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[fill_idx] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    mreq_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tags are qualified by valid_q, so they need no reset.
    always_ff @(posedge w_clk) begin
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    m_icache_data #(
        .DEPTH (LINES * WORDS),
        .AW    (AW)
    ) u_data (
        .clk_i   (w_clk),
        .we_i    (beat_we),
        .waddr_i ({fill_idx, cnt_q}),
        .wdata_i (w_mdata),
        .raddr_i ({pc_idx, pc_off}),
        .rdata_o (rd_word)
    );

    assign w_hit   = lookup_hit;
    assign w_ir    = lookup_hit ? rd_word : NOP;
    assign w_stall = (state_q != ST_IDLE) || (w_req && !lookup_hit);
    assign w_mreq  = mreq_q;
    assign w_maddr = maddr_q;

endmodule

// File: tb/tb_m_icache.sv
// tb_m_icache: directed self-checking bench for m_icache (LINES=16, WORDS=4).
// Latency: inputs driven just after the falling edge, outputs sampled 1 ns later.
// Backpressure: the bench plays the backing memory, with immediate or delayed w_mack.
module tb_m_icache;

    logic        w_clk;
    logic        w_rst;
    logic        w_req;
    logic [31:0] w_pc;
    logic        w_inv;
    logic [31:0] w_ir;
    logic        w_hit;
    logic        w_stall;
    logic        w_mreq;
    logic [31:0] w_maddr;
    logic        w_mack;
    logic        w_mvalid;
    logic [31:0] w_mdata;

    int checks = 0;
    int errors = 0;

    m_icache #(.LINES(16), .WORDS(4)) dut (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_req    (w_req),
        .w_pc     (w_pc),
        .w_inv    (w_inv),
        .w_ir     (w_ir),
        .w_hit    (w_hit),
        .w_stall  (w_stall),
        .w_mreq   (w_mreq),
        .w_maddr  (w_maddr),
        .w_mack   (w_mack),
        .w_mvalid (w_mvalid),
        .w_mdata  (w_mdata)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Backing-memory contents: the 0x100 line is the program from the plan, others a tagged pattern.
    function automatic logic [31:0] wd(input logic [31:0] a, input int i);
        logic [31:0] r;
        if (a == 32'h100) begin
            case (i)
                0:       r = 32'h0010_0093;
                1:       r = 32'h0020_0113;
                2:       r = 32'h0020_81B3;
                default: r = 32'h0000_0013;
            endcase
        end else begin
            r = 32'hC000_0000 | a | 32'(i);
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge w_clk);
    endtask

    // Caller has just presented a missing address. Ack at once, then four back-to-back
    // beats; w_inv is pulsed alongside beat inv_beat (-1 for none). Ends in IDLE.
    task automatic refill(input logic [31:0] a, input int inv_beat);
        tick();
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1;
            w_mdata  = wd(a, i);
            w_inv    = (i == inv_beat);
            tick();
        end
        w_mvalid = 1'b0;
        w_inv    = 1'b0;
    endtask

    task automatic test_reset();
        w_rst = 1'b1; w_req = 1'b0; w_pc = '0; w_inv = 1'b0;
        w_mack = 1'b0; w_mvalid = 1'b0; w_mdata = '0;
        tick(); tick();
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", w_hit); end
        checks++; if (w_ir !== 32'h13) begin errors++; $display("FAIL reset_ir got %h exp 00000013", w_ir); end
        checks++; if (w_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", w_stall); end
        checks++; if (w_mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b exp 0", w_mreq); end
        checks++; if (w_maddr !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h exp 0", w_maddr); end
        tick();
        w_rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        w_req = 1'b1; w_pc = 32'h100;
        #1;
        checks++; if (w_stall !== 1'b1) begin errors++; $display("FAIL cold_stall got %b exp 1", w_stall); end
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL cold_hit got %b exp 0", w_hit); end
        checks++; if (w_ir !== 32'h13) begin errors++; $display("FAIL cold_ir got %h exp 00000013", w_ir); end
        tick();
        #1;
        checks++; if (w_mreq !== 1'b1) begin errors++; $display("FAIL cold_mreq got %b exp 1", w_mreq); end
        checks++; if (w_maddr !== 32'h100) begin errors++; $display("FAIL cold_maddr got %h exp 00000100", w_maddr); end
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h100, i);
            #1;
            checks++; if (w_stall !== 1'b1) begin errors++; $display("FAIL cold_fill_stall beat %0d got %b exp 1", i, w_stall); end
            tick();
        end
        w_mvalid = 1'b0;
        #1;
        checks++; if (w_hit !== 1'b1) begin errors++; $display("FAIL cold_after_hit got %b exp 1", w_hit); end
        checks++; if (w_ir !== 32'h0010_0093) begin errors++; $display("FAIL cold_after_ir got %h exp 00100093", w_ir); end
        checks++; if (w_stall !== 1'b0) begin errors++; $display("FAIL cold_after_stall got %b exp 0", w_stall); end
        tick();
    endtask

    task automatic test_spatial_hit();
        w_pc = 32'h108;
        #1;
        checks++; if (w_hit !== 1'b1) begin errors++; $display("FAIL spatial_hit got %b exp 1", w_hit); end
        checks++; if (w_ir !== 32'h0020_81B3) begin errors++; $display("FAIL spatial_ir got %h exp 002081b3", w_ir); end
        tick();
        #1;
        checks++; if (w_mreq !== 1'b0) begin errors++; $display("FAIL spatial_mreq got %b exp 0", w_mreq); end
        w_pc = 32'h104;
        #1;
        checks++; if (w_ir !== 32'h0020_0113) begin errors++; $display("FAIL spatial_ir4 got %h exp 00200113", w_ir); end
        w_req = 1'b0;
        #1;
        checks++; if (w_hit !== 1'b0 || w_stall !== 1'b0) begin errors++; $display("FAIL idle_noreq got hit=%b stall=%b exp 0/0", w_hit, w_stall); end
        tick();
    endtask

    task automatic test_conflict();
        w_req = 1'b1; w_pc = 32'h200;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL conflict_200_hit got %b exp 0", w_hit); end
        refill(32'h200, -1);
        w_pc = 32'h204;
        #1;
        checks++; if (w_ir !== 32'hC000_0201) begin errors++; $display("FAIL conflict_204_ir got %h exp c0000201", w_ir); end
        tick();
        w_pc = 32'h100;
        #1;
        checks++; if (w_hit !== 1'b0 || w_stall !== 1'b1) begin errors++; $display("FAIL conflict_100 got hit=%b stall=%b exp 0/1", w_hit, w_stall); end
        tick();
        #1;
        checks++; if (w_maddr !== 32'h100 || w_mreq !== 1'b1) begin errors++; $display("FAIL conflict_maddr got %h mreq=%b exp 00000100/1", w_maddr, w_mreq); end
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h100, i);
            tick();
        end
        w_mvalid = 1'b0;
        w_pc = 32'h10C;
        #1;
        checks++; if (w_hit !== 1'b1 || w_ir !== 32'h13) begin errors++; $display("FAIL conflict_10c got hit=%b ir=%h exp 1/00000013", w_hit, w_ir); end
        tick();
    endtask

    task automatic test_delayed_ack();
        w_pc = 32'h140;
        tick();
        for (int c = 0; c < 5; c++) begin
            w_mack = 1'b0; w_mvalid = 1'b1; w_mdata = 32'hDEAD_0000 | 32'(c);
            #1;
            checks++; if (w_mreq !== 1'b1 || w_maddr !== 32'h140) begin errors++; $display("FAIL dack_hold cyc %0d got mreq=%b maddr=%h exp 1/00000140", c, w_mreq, w_maddr); end
            tick();
        end
        w_mvalid = 1'b0; w_mack = 1'b1;
        #1;
        checks++; if (w_mreq !== 1'b1) begin errors++; $display("FAIL dack_mreq_at_ack got %b exp 1", w_mreq); end
        tick();
        w_mack = 1'b0;
        #1;
        checks++; if (w_mreq !== 1'b0) begin errors++; $display("FAIL dack_mreq_after got %b exp 0", w_mreq); end
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h140, i);
            tick();
        end
        w_mvalid = 1'b0;
        #1;
        checks++; if (w_ir !== 32'hC000_0140) begin errors++; $display("FAIL dack_w0 got %h exp c0000140", w_ir); end
        w_pc = 32'h14C;
        #1;
        checks++; if (w_ir !== 32'hC000_0143) begin errors++; $display("FAIL dack_w3 got %h exp c0000143", w_ir); end
        tick();
    endtask

    task automatic test_inv_fill();
        w_pc = 32'h300;
        refill(32'h300, 1);
        #1;
        checks++; if (w_hit !== 1'b0 || w_stall !== 1'b1) begin errors++; $display("FAIL invfill_300 got hit=%b stall=%b exp 0/1", w_hit, w_stall); end
        w_pc = 32'h140;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invfill_140 got %b exp 0", w_hit); end
        w_pc = 32'h100;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invfill_100 got %b exp 0", w_hit); end
        w_pc = 32'h140;
        refill(32'h140, -1);
        w_pc = 32'h300;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invfill_300_again got %b exp 0", w_hit); end
        refill(32'h300, -1);
        #1;
        checks++; if (w_hit !== 1'b1 || w_ir !== 32'hC000_0300) begin errors++; $display("FAIL invfill_300_ok got hit=%b ir=%h exp 1/c0000300", w_hit, w_ir); end
        tick();
    endtask

    task automatic test_inv_idle();
        w_pc = 32'h144; w_inv = 1'b1;
        #1;
        checks++; if (w_hit !== 1'b1 || w_ir !== 32'hC000_0141) begin errors++; $display("FAIL invidle_same got hit=%b ir=%h exp 1/c0000141", w_hit, w_ir); end
        tick();
        w_inv = 1'b0; w_pc = 32'h140;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invidle_140 got %b exp 0", w_hit); end
        refill(32'h140, -1);
        // invalidate and miss together: refill of 0x300 starts, 0x140 is dropped
        w_pc = 32'h300; w_inv = 1'b1;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invmiss_300 got %b exp 0", w_hit); end
        tick();
        w_inv = 1'b0;
        #1;
        checks++; if (w_mreq !== 1'b1 || w_maddr !== 32'h300) begin errors++; $display("FAIL invmiss_req got mreq=%b maddr=%h exp 1/00000300", w_mreq, w_maddr); end
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h300, i);
            tick();
        end
        w_mvalid = 1'b0;
        w_pc = 32'h308;
        #1;
        checks++; if (w_hit !== 1'b1 || w_ir !== 32'hC000_0302) begin errors++; $display("FAIL invmiss_308 got hit=%b ir=%h exp 1/c0000302", w_hit, w_ir); end
        w_pc = 32'h140;
        #1;
        checks++; if (w_hit !== 1'b0) begin errors++; $display("FAIL invmiss_140 got %b exp 0", w_hit); end
        refill(32'h140, -1);
    endtask

    task automatic test_reset_mid_fill();
        w_pc = 32'h100;
        tick();
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h100, i);
            tick();
        end
        w_mvalid = 1'b0; w_req = 1'b0;
        #1;
        checks++; if (w_stall !== 1'b1) begin errors++; $display("FAIL midfill_stall_pre got %b exp 1", w_stall); end
        w_rst = 1'b1;
        #1;
        checks++; if (w_stall !== 1'b0 || w_mreq !== 1'b0) begin errors++; $display("FAIL midfill_rst got stall=%b mreq=%b exp 0/0", w_stall, w_mreq); end
        tick();
        w_rst = 1'b0;
        tick();
        w_req = 1'b1; w_pc = 32'h100;
        #1;
        checks++; if (w_hit !== 1'b0 || w_stall !== 1'b1) begin errors++; $display("FAIL midfill_after got hit=%b stall=%b exp 0/1", w_hit, w_stall); end
        tick();
        #1;
        checks++; if (w_mreq !== 1'b1 || w_maddr !== 32'h100) begin errors++; $display("FAIL midfill_req got mreq=%b maddr=%h exp 1/00000100", w_mreq, w_maddr); end
        w_mack = 1'b1;
        tick();
        w_mack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_mvalid = 1'b1; w_mdata = wd(32'h100, i);
            tick();
        end
        w_mvalid = 1'b0;
        w_pc = 32'h104;
        #1;
        checks++; if (w_hit !== 1'b1 || w_ir !== 32'h0020_0113) begin errors++; $display("FAIL midfill_refill got hit=%b ir=%h exp 1/00200113", w_hit, w_ir); end
        tick();
        w_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_delayed_ack();
        test_inv_fill();
        test_inv_idle();
        test_reset_mid_fill();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/m_icache.md
Name: m_icache

Overview:
- Direct-mapped instruction cache sitting directly upstream of the pipelined core's IF stage.
- Replaces the async-read instruction memory.
- Takes the fetch PC (r_pc, after branch-prediction select) and returns the instruction word in the same cycle on a hit.
- On a miss it stalls fetch and refills one line from a slower backing memory through a req/ack + beat-valid interface.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
w_clk  in  1  clock, all state updates on rising edge
w_rst  in  1  asynchronous reset, active-high
w_req  in  1  fetch request valid for w_pc this cycle
w_pc  in  32  fetch byte address (bits [1:0] ignored)
w_inv  in  1  invalidate all lines (fence.i), single-cycle pulse
w_ir  out  32  instruction word; 32'h13 (nop) when w_hit=0
w_hit  out  1  w_ir valid for w_pc this cycle
w_stall  out  1  fetch must hold r_pc and pipeline-register inputs this cycle
w_mreq  out  1  line-refill request to backing memory
w_maddr  out  32  line-aligned refill address
w_mack  in  1  backing memory accepts request this cycle
w_mvalid  in  1  refill data beat valid
w_mdata  in  32  refill data beat

Behaviour:
- Address split: word offset = pc[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
  - For defaults: offset [3:2], index [7:4], tag [31:8].
- Storage:
  - valid bit per line.
  - tag array.
  - data array of LINES*WORDS words: asynchronous read, synchronous write.
- Hit is combinational: w_hit = w_req & state==IDLE & valid[index] & tag match. w_ir = data[index][offset] when w_hit, else 32'h13.
- w_stall = (state!=IDLE) | (w_req & !w_hit).
- FSM states:
  - IDLE:
    - w_req & miss -> REQ.
    - Latch line address {pc[31:log2(WORDS)+2], zeros} into w_maddr register.
  - REQ:
    - w_mreq=1; w_maddr held stable until w_mack.
    - The request must never be withdrawn.
    - w_mack -> FILL, beat counter=0.
    - w_mvalid in REQ is ignored.
  - FILL:
    - Each w_mvalid writes w_mdata to data[latched index][counter], then counter+1.
    - Beats arrive in ascending word order.
    - On beat WORDS-1: set valid[index]=1 and tag[index]=latched tag, then go to IDLE.
  - Returning to IDLE: the re-presented PC hits on the next cycle.
- Miss latency (w_mack in the first REQ cycle, back-to-back beats): the miss cycle, plus 1 REQ cycle, plus WORDS FILL cycles, then a hit in the following cycle.
- Fetch PC change during refill (branch redirect): the refill runs to completion and the line is installed. The new PC is looked up in IDLE afterwards. No abort path.
- w_inv handling:
  - In IDLE: clears all valid bits at the edge. A same-cycle lookup still uses the pre-invalidate valid bits.
  - During REQ/FILL: the request is latched in an inv_pending flag, applied on the edge that completes the fill, and the just-filled line ends invalid. inv_pending is then cleared.
  - w_inv together with a miss in IDLE: invalidate takes effect and refill starts on the same edge.
- Reset (async, any state, including mid-FILL):
  - state=IDLE, all valid=0, counter=0, inv_pending=0, w_mreq=0, w_maddr=0.
  - Hence w_hit=0 and w_ir=32'h13. w_stall=0 while w_req=0.
  - The backing memory is reset by the same w_rst. Partially written data words are don't-care since the line stays invalid.
- Tag and data arrays are not reset; only the valid bits are.

Decomposition:
- Shared package: state encoding (IDLE/REQ/FILL), NOP constant 32'h13, derived widths (OFF_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=30-OFF_W-IDX_W).
- One sub-module: m_icache_data, the LINES*WORDS x 32 data array with async read port and single sync write port. FSM, tags and valid bits stay in m_icache.

Test Plan:
- Cold miss with LINES=16, WORDS=4:
  - Reset, then w_req=1, w_pc=0x100 -> w_stall=1, w_hit=0, w_ir=0x13; next cycle w_mreq=1, w_maddr=0x100.
  - Ack, then beats 0x00100093, 0x00200113, 0x002081B3, 0x00000013 -> the cycle after the last beat gives w_hit=1, w_ir=0x00100093, w_stall=0.
- Spatial hit: after the above, w_pc=0x108 -> w_hit=1 same cycle, w_ir=0x002081B3, w_mreq stays 0.
- Conflict eviction:
  - w_pc=0x200 (index 0, new tag) -> full refill.
  - Then w_pc=0x100 -> miss again, w_maddr=0x100.
- Delayed ack:
  - w_mack held low 5 cycles with w_mvalid=1 pulses during REQ -> w_mreq stays 1, w_maddr stable, pulses ignored.
  - Counter starts only after ack; the line is correct after 4 post-ack beats.
- Invalidate during refill:
  - Pulse w_inv during FILL of 0x300 -> after completion, 0x300 misses again and 0x100 (previously valid) misses.
  - w_inv in IDLE -> all previous lines miss on the next cycle.
- Async reset mid-FILL: assert w_rst after beat 2 of 0x100 -> w_mreq=0 and w_stall=0 immediately without a clock edge; after release, w_pc=0x100 misses and issues a new request.
